dcache_port_arbiter: RTL
========================

Name: dcache_port_arbiter

Overview:
- Shares the single D-cache request port between two requesters: pipeline MEM-stage accesses, and value-prediction verify loads queued by the value-prediction logic after a load miss was predicted.
- Buffers verify loads in a small FIFO and replays them to the cache when the port is free.
- Compares each returned word with its predicted value and reports match or mismatch so recovery can be triggered.
- Sits between the hazard/value-prediction control and the D-cache, replacing ad-hoc request-hold muxing.

Parameters:
- VQ_DEPTH, 4, verify-queue entries (power of 2, ≥2)
- STARVE_LIMIT, 8, consecutive pipe grants allowed while the verify queue is non-empty
- ID_W, 3, verify tag width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- pipe_valid  in  1  pipeline request; held stable until pipe_resp_valid
- pipe_write  in  1  1=store, 0=load
- pipe_addr  in  `ADDR_WIDTH  byte address
- pipe_wdata  in  `DATA_WIDTH  store data
- pipe_resp_valid  out  1  one-cycle completion pulse
- pipe_resp_data  out  `DATA_WIDTH  load data, valid with pulse
- vq_enq  in  1  push verify entry
- vq_addr  in  `ADDR_WIDTH  load address to re-read
- vq_pred  in  `DATA_WIDTH  predicted value
- vq_id  in  ID_W  tag
- vq_full  out  1  queue full; vq_enq ignored when high
- vq_empty  out  1  queue empty and no verify in flight
- vq_flush  in  1  discard all queued verify entries
- ver_valid  out  1  one-cycle verify result pulse
- ver_match  out  1  returned data == predicted
- ver_id  out  ID_W  tag of result
- dc_req_valid  out  1  cache request
- dc_req_write  out  1
- dc_req_addr  out  `ADDR_WIDTH
- dc_req_data  out  `DATA_WIDTH
- dc_resp_valid  in  1  cache done for current request
- dc_resp_data  in  `DATA_WIDTH

Behaviour:
- Reset: state IDLE; FIFO pointers/count 0; starve counter 0; all outputs 0 except vq_empty=1. Reset mid-transaction abandons the held request; dc_req_valid is 0 in the cycle after rst.
- FSM states:
  - IDLE: arbitrate. Winner latched into the hold register; go to PIPE_BUSY or VQ_BUSY.
  - PIPE_BUSY / VQ_BUSY: dc_req_* driven from the hold register, constant until dc_resp_valid; then return to IDLE.
  - Latency: grant edge N → dc_req_valid from cycle N+1. The cycle dc_resp_valid=1 is the last request cycle. Back-to-back grants are allowed: IDLE may re-grant in the cycle after completion.
- Arbitration (IDLE):
  - Pipe wins if pipe_valid, unless one of the following holds:
    - (a) starve counter == STARVE_LIMIT and the queue is non-empty;
    - (b) pipe_write=1 and pipe_addr[ADDR_WIDTH-1:2] matches any valid queued vq_addr[ADDR_WIDTH-1:2] (store must not overtake an older verify load to the same word).
  - In cases (a)/(b) the queue head wins.
  - Queue head wins when pipe_valid=0.
- Starve counter: +1 on each pipe grant while the queue is non-empty (saturates at STARVE_LIMIT); cleared on any VQ grant or when the queue is empty.
- Pipe completion: pipe_resp_valid=dc_resp_valid & PIPE_BUSY (combinational), pipe_resp_data=dc_resp_data.
- Verify completion: in VQ_BUSY with dc_resp_valid, registered outputs next cycle:
  - ver_valid=1;
  - ver_id=held id;
  - ver_match=(dc_resp_data==held pred);
  - suppressed if vq_flush occurred while in flight.
- FIFO:
  - Entry {addr,pred,id}. Dequeue on VQ grant (the entry moves to the hold register).
  - Enqueue when vq_enq & ~vq_full.
  - Simultaneous enq+deq on a full queue: deq happens, enq is still rejected (vq_full evaluated before the edge).
  - Pointers wrap modulo VQ_DEPTH.
  - The address-match check covers valid entries only.
- vq_flush:
  - Clears count/pointers next cycle.
  - An in-flight verify runs to completion on the cache (request must stay stable), but its result is dropped.
  - vq_enq in the same cycle as vq_flush is ignored.
  - Pending pipe requests are unaffected.
- vq_empty = count==0 & ~VQ_BUSY.
- Only word accesses; dc_req_addr is passed unmodified.

Decomposition:
- mips_core_pkg additions:
  - arb_state_t enum {ARB_IDLE, ARB_PIPE_BUSY, ARB_VQ_BUSY};
  - vq_entry_t struct {addr, pred, id}.
- `ADDR_WIDTH and `DATA_WIDTH come from mips_core.svh.
- One sub-module: verify_queue (FIFO storage, pointers, count, full/empty, parallel word-address match output). Arbiter FSM, starve counter and compare stay in the top level.

Test Plan:
- Lone pipe load 0x100, cache responds 3 cycles after request with 0xDEAD_BEEF → dc_req_valid high 3 cycles with addr 0x100, pipe_resp_valid one pulse with data 0xDEAD_BEEF; state back to IDLE.
- Enqueue {0x200, pred 0x5, id 2}, no pipe traffic, cache returns 0x5 → ver_valid pulse, ver_match=1, ver_id=2. Repeat with return 0x6 → ver_match=0.
- Queue holds one entry and the pipe issues 10 back-to-back loads with STARVE_LIMIT=8 → exactly 8 pipe grants, then one VQ grant, then the remaining 2 pipe loads.
- Queue holds {0x300}; pipe store to 0x302 → VQ read of 0x300 issued first, store issued after it completes. Store to 0x304 → store granted first.
- Fill 4 entries, then assert vq_enq → vq_full=1, 5th entry lost. vq_flush during an in-flight verify → no ver_valid, vq_empty=1 after the cache completes.
- rst asserted while PIPE_BUSY → next cycle dc_req_valid=0, vq_empty=1, no pipe_resp_valid or ver_valid pulses.

Source files
------------

// File: rtl/dcache_port_arbiter_pkg.sv
// Shared widths, arbiter state encoding and word-address helper for the
// D-cache port arbiter and its verify queue.
package dcache_port_arbiter_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE      = 2'd0;
  localparam arb_state_t ARB_PIPE_BUSY = 2'd1;
  localparam arb_state_t ARB_VQ_BUSY   = 2'd2;

  // Word index of a byte address; stores and verify loads collide on this.
  function automatic logic [ADDR_WIDTH-3:0] word_of(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1:2];
  endfunction

endpackage

// File: rtl/dcache_port_arbiter_verify_queue.sv
// FIFO of pending value-prediction verify loads with a parallel word-address
// match across the valid entries.
module verify_queue
  import dcache_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq,
  input  logic [ADDR_WIDTH-1:0] enq_addr,
  input  logic [DATA_WIDTH-1:0] enq_pred,
  input  logic [ID_W-1:0]       enq_id,
  input  logic                  deq,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-3:0] match_word,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [DATA_WIDTH-1:0] head_pred,
  output logic [ID_W-1:0]       head_id,
  output logic                  full,
  output logic                  empty,
  output logic                  match
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] pred_mem [DEPTH];
  logic [ID_W-1:0]       id_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [DEPTH-1:0] hit;
  logic             do_enq;
  logic             do_deq;

  // Full/empty are taken before the edge, so a deq on a full queue never frees
  // room for a same-cycle enq.
  assign full   = (count_reg == CNT_W'(DEPTH));
  assign empty  = (count_reg == '0);
  assign do_enq = enq & ~full & ~flush;
  assign do_deq = deq & ~empty & ~flush;

  assign head_addr = addr_mem[rd_ptr_reg];
  assign head_pred = pred_mem[rd_ptr_reg];
  assign head_id   = id_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(do_enq) - CNT_W'(do_deq);
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) begin
      addr_mem[wr_ptr_reg] <= enq_addr;
      pred_mem[wr_ptr_reg] <= enq_pred;
      id_mem[wr_ptr_reg]   <= enq_id;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      logic [PTR_W-1:0] offset;
      assign offset  = PTR_W'(gi) - rd_ptr_reg;
      assign hit[gi] = ({1'b0, offset} < count_reg) &&
                       (word_of(addr_mem[gi]) == match_word);
    end
  endgenerate

  assign match = |hit;

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the D-cache request port between MEM-stage accesses and queued
// value-prediction verify loads, and reports verify match/mismatch.
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int VQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int ID_W         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_valid,
  input  logic                  pipe_write,
  input  logic [ADDR_WIDTH-1:0] pipe_addr,
  input  logic [DATA_WIDTH-1:0] pipe_wdata,
  output logic                  pipe_resp_valid,
  output logic [DATA_WIDTH-1:0] pipe_resp_data,
  input  logic                  vq_enq,
  input  logic [ADDR_WIDTH-1:0] vq_addr,
  input  logic [DATA_WIDTH-1:0] vq_pred,
  input  logic [ID_W-1:0]       vq_id,
  output logic                  vq_full,
  output logic                  vq_empty,
  input  logic                  vq_flush,
  output logic                  ver_valid,
  output logic                  ver_match,
  output logic [ID_W-1:0]       ver_id,
  output logic                  dc_req_valid,
  output logic                  dc_req_write,
  output logic [ADDR_WIDTH-1:0] dc_req_addr,
  output logic [DATA_WIDTH-1:0] dc_req_data,
  input  logic                  dc_resp_valid,
  input  logic [DATA_WIDTH-1:0] dc_resp_data
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t            state_reg;
  logic                  hold_write_reg;
  logic [ADDR_WIDTH-1:0] hold_addr_reg;
  logic [DATA_WIDTH-1:0] hold_data_reg;
  logic [DATA_WIDTH-1:0] hold_pred_reg;
  logic [ID_W-1:0]       hold_id_reg;
  logic                  flushed_reg;
  logic [SW-1:0]         starve_reg;
  logic                  ver_valid_reg;
  logic                  ver_match_reg;
  logic [ID_W-1:0]       ver_id_reg;

  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_pred;
  logic [ID_W-1:0]       head_id;
  logic                  q_empty;
  logic                  q_match;
  logic                  vq_ready;
  logic                  starved;
  logic                  store_hazard;
  logic                  grant_pipe;
  logic                  grant_vq;

  verify_queue #(
    .DEPTH (VQ_DEPTH),
    .ID_W  (ID_W)
  ) u_vq (
    .clk        (clk),
    .rst        (rst),
    .enq        (vq_enq),
    .enq_addr   (vq_addr),
    .enq_pred   (vq_pred),
    .enq_id     (vq_id),
    .deq        (grant_vq),
    .flush      (vq_flush),
    .match_word (word_of(pipe_addr)),
    .head_addr  (head_addr),
    .head_pred  (head_pred),
    .head_id    (head_id),
    .full       (vq_full),
    .empty      (q_empty),
    .match      (q_match)
  );

  // A queue being flushed this cycle is treated as already empty for grants.
  always_comb begin
    vq_ready     = ~q_empty & ~vq_flush;
    starved      = (starve_reg == SW'(STARVE_LIMIT)) & ~q_empty;
    store_hazard = pipe_valid & pipe_write & q_match;
    grant_pipe   = (state_reg == ARB_IDLE) & pipe_valid &
                   ~(vq_ready & (starved | store_hazard));
    grant_vq     = (state_reg == ARB_IDLE) & vq_ready & ~grant_pipe;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ARB_IDLE;
      hold_write_reg <= 1'b0;
      hold_addr_reg  <= '0;
      hold_data_reg  <= '0;
      hold_pred_reg  <= '0;
      hold_id_reg    <= '0;
      flushed_reg    <= 1'b0;
      starve_reg     <= '0;
      ver_valid_reg  <= 1'b0;
      ver_match_reg  <= 1'b0;
      ver_id_reg     <= '0;
    end else begin
      ver_valid_reg <= 1'b0;
      case (state_reg)
        ARB_IDLE: begin
          if (grant_pipe) begin
            state_reg      <= ARB_PIPE_BUSY;
            hold_write_reg <= pipe_write;
            hold_addr_reg  <= pipe_addr;
            hold_data_reg  <= pipe_wdata;
          end else if (grant_vq) begin
            state_reg      <= ARB_VQ_BUSY;
            hold_write_reg <= 1'b0;
            hold_addr_reg  <= head_addr;
            hold_data_reg  <= '0;
            hold_pred_reg  <= head_pred;
            hold_id_reg    <= head_id;
            flushed_reg    <= 1'b0;
          end
        end
        ARB_PIPE_BUSY: begin
          if (dc_resp_valid) state_reg <= ARB_IDLE;
        end
        ARB_VQ_BUSY: begin
          // A flushed verify still finishes on the cache; only its result is dropped.
          if (vq_flush) flushed_reg <= 1'b1;
          if (dc_resp_valid) begin
            state_reg     <= ARB_IDLE;
            ver_valid_reg <= ~flushed_reg & ~vq_flush;
            ver_id_reg    <= hold_id_reg;
            ver_match_reg <= (dc_resp_data == hold_pred_reg);
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase

      if (q_empty || grant_vq) starve_reg <= '0;
      else if (grant_pipe && starve_reg != SW'(STARVE_LIMIT)) starve_reg <= starve_reg + 1'b1;
    end
  end

  assign dc_req_valid    = (state_reg != ARB_IDLE);
  assign dc_req_write    = hold_write_reg;
  assign dc_req_addr     = hold_addr_reg;
  assign dc_req_data     = hold_data_reg;
  assign pipe_resp_valid = dc_resp_valid & (state_reg == ARB_PIPE_BUSY);
  assign pipe_resp_data  = pipe_resp_valid ? dc_resp_data : '0;
  assign vq_empty        = q_empty & (state_reg != ARB_VQ_BUSY);
  assign ver_valid       = ver_valid_reg;
  assign ver_match       = ver_match_reg;
  assign ver_id          = ver_id_reg;

endmodule
